// File: rtl/trellis_io_pkg.sv
// Shared types and constants for the TRELLIS_IO-style pad bank on the FT2232 FIFO bus.
package trellis_io_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;

    localparam string DIR_STR_INPUT  = "INPUT";
    localparam string DIR_STR_OUTPUT = "OUTPUT";
    localparam string DIR_STR_BIDIR  = "BIDIR";

    typedef enum logic [1:0] {
        DIR_INPUT  = 2'd0,
        DIR_OUTPUT = 2'd1,
        DIR_BIDIR  = 2'd2
    } dir_e;

endpackage

// File: rtl/trellis_io_cell.sv
// One pad bit: tristate driver plus unconditional read-back of the pad.
module trellis_io_cell
    import trellis_io_pkg::*;
#(
    parameter dir_e MODE = DIR_BIDIR
) (
    inout  wire  b,
    input  logic t_e,
    input  logic i_e,
    output logic o_c,
    output logic drive_c
);

    // Only a clean 0 on t_e enables the driver; X/Z releases the pad.
    always_comb begin
        drive_c = 1'b0;
        case (MODE)
            DIR_OUTPUT: drive_c = 1'b1;
            DIR_BIDIR:  drive_c = (t_e === 1'b0);
            default:    drive_c = 1'b0;
        endcase
    end

    assign b   = drive_c ? i_e : 1'bz;
    assign o_c = b;

endmodule

// File: rtl/trellis_io_bank.sv
// WIDTH-bit bidirectional pad bank with optional I/O registering and a bus-turnaround counter.
module trellis_io_bank
    import trellis_io_pkg::*;
#(
    parameter int unsigned WIDTH   = DEFAULT_WIDTH,
    parameter string       DIR     = DIR_STR_BIDIR,
    parameter bit          REG_OUT = 1'b0,
    parameter bit          REG_IN  = 1'b0,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             fifo_clk_o,
    input  logic             ft2232_reset_n_i,
    inout  wire  [WIDTH-1:0] B,
    input  logic             T,
    input  logic [WIDTH-1:0] I,
    output logic [WIDTH-1:0] O,
    output logic             drive_o,
    output logic [CNT_W-1:0] turn_cnt_o
);

    localparam dir_e MODE = (DIR == DIR_STR_INPUT)  ? DIR_INPUT  :
                            (DIR == DIR_STR_OUTPUT) ? DIR_OUTPUT : DIR_BIDIR;

    logic             t_e;
    logic [WIDTH-1:0] i_e;
    logic [WIDTH-1:0] o_raw;
    logic [WIDTH-1:0] drive_bits;
    logic             t_bit;
    logic             t_prev;

    // Output-side controls; the async reset releases the pad immediately when registered.
    generate
        if (REG_OUT) begin : g_reg_out
            always_ff @(posedge fifo_clk_o or negedge ft2232_reset_n_i) begin
                if (!ft2232_reset_n_i) begin
                    t_e <= 1'b1;
                    i_e <= '0;
                end else begin
                    t_e <= T;
                    i_e <= I;
                end
            end
        end else begin : g_comb_out
            assign t_e = T;
            assign i_e = I;
        end
    endgenerate

    generate
        for (genvar g = 0; g < int'(WIDTH); g++) begin : g_cell
            trellis_io_cell #(
                .MODE (MODE)
            ) u_cell (
                .b       (B[g]),
                .t_e     (t_e),
                .i_e     (i_e[g]),
                .o_c     (o_raw[g]),
                .drive_c (drive_bits[g])
            );
        end
    endgenerate

    assign drive_o = |drive_bits;

    generate
        if (REG_IN) begin : g_reg_in
            always_ff @(posedge fifo_clk_o or negedge ft2232_reset_n_i) begin
                if (!ft2232_reset_n_i) begin
                    O <= '0;
                end else begin
                    O <= o_raw;
                end
            end
        end else begin : g_comb_in
            assign O = o_raw;
        end
    endgenerate

    // Fail-safe view of t_e so an X/Z control counts as released.
    assign t_bit = (t_e === 1'b0) ? 1'b0 : 1'b1;

    // Saturating count of direction changes; only meaningful for a bidirectional bank.
    always_ff @(posedge fifo_clk_o or negedge ft2232_reset_n_i) begin
        if (!ft2232_reset_n_i) begin
            t_prev     <= 1'b1;
            turn_cnt_o <= '0;
        end else begin
            t_prev <= t_bit;
            if ((MODE == DIR_BIDIR) && (t_prev != t_bit) && (turn_cnt_o != '1)) begin
                turn_cnt_o <= turn_cnt_o + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_trellis_io_bank.sv
// Directed self-checking bench for trellis_io_bank across DIR/REG_OUT/REG_IN/CNT_W variants.
module tb_trellis_io_bank;

    logic fifo_clk_o;
    logic ft2232_reset_n_i;

    int n_pass;
    int n_total;

    // u0: BIDIR comb, u1: BIDIR with 2-bit counter (shares T/I with u0)
    logic        t0;
    logic [7:0]  i0;
    wire  [7:0]  b0;
    wire  [7:0]  b1;
    logic [7:0]  tb_b0;
    logic        tb_en0;
    logic [7:0]  o0, o1;
    logic        drv0, drv1;
    logic [15:0] cnt0;
    logic [1:0]  cnt1;

    // u2: REG_OUT=1
    logic        t2;
    logic [7:0]  i2;
    wire  [7:0]  b2;
    logic [7:0]  tb_b2;
    logic        tb_en2;
    logic [7:0]  o2;
    logic        drv2;
    logic [15:0] cnt2;

    // u3: INPUT
    logic        t3;
    logic [7:0]  i3;
    wire  [7:0]  b3;
    logic [7:0]  tb_b3;
    logic        tb_en3;
    logic [7:0]  o3;
    logic        drv3;
    logic [15:0] cnt3;

    // u4: REG_IN=1
    wire  [7:0]  b4;
    logic [7:0]  tb_b4;
    logic        tb_en4;
    logic [7:0]  o4;
    logic        drv4;
    logic [15:0] cnt4;

    assign b0 = tb_en0 ? tb_b0 : 8'bz;
    assign b2 = tb_en2 ? tb_b2 : 8'bz;
    assign b3 = tb_en3 ? tb_b3 : 8'bz;
    assign b4 = tb_en4 ? tb_b4 : 8'bz;

    trellis_io_bank #(.WIDTH(8), .DIR("BIDIR"), .REG_OUT(1'b0), .REG_IN(1'b0), .CNT_W(16)) u0 (
        .fifo_clk_o(fifo_clk_o), .ft2232_reset_n_i(ft2232_reset_n_i),
        .B(b0), .T(t0), .I(i0), .O(o0), .drive_o(drv0), .turn_cnt_o(cnt0));

    trellis_io_bank #(.WIDTH(8), .DIR("BIDIR"), .REG_OUT(1'b0), .REG_IN(1'b0), .CNT_W(2)) u1 (
        .fifo_clk_o(fifo_clk_o), .ft2232_reset_n_i(ft2232_reset_n_i),
        .B(b1), .T(t0), .I(i0), .O(o1), .drive_o(drv1), .turn_cnt_o(cnt1));

    trellis_io_bank #(.WIDTH(8), .DIR("BIDIR"), .REG_OUT(1'b1), .REG_IN(1'b0), .CNT_W(16)) u2 (
        .fifo_clk_o(fifo_clk_o), .ft2232_reset_n_i(ft2232_reset_n_i),
        .B(b2), .T(t2), .I(i2), .O(o2), .drive_o(drv2), .turn_cnt_o(cnt2));

    trellis_io_bank #(.WIDTH(8), .DIR("INPUT"), .REG_OUT(1'b0), .REG_IN(1'b0), .CNT_W(16)) u3 (
        .fifo_clk_o(fifo_clk_o), .ft2232_reset_n_i(ft2232_reset_n_i),
        .B(b3), .T(t3), .I(i3), .O(o3), .drive_o(drv3), .turn_cnt_o(cnt3));

    trellis_io_bank #(.WIDTH(8), .DIR("BIDIR"), .REG_OUT(1'b0), .REG_IN(1'b1), .CNT_W(16)) u4 (
        .fifo_clk_o(fifo_clk_o), .ft2232_reset_n_i(ft2232_reset_n_i),
        .B(b4), .T(1'b1), .I(8'h00), .O(o4), .drive_o(drv4), .turn_cnt_o(cnt4));

    initial fifo_clk_o = 1'b0;
    always #5 fifo_clk_o = ~fifo_clk_o;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge fifo_clk_o);
        #1;
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        ft2232_reset_n_i = 1'b0;
        t0 = 1'b1; i0 = 8'h00; tb_b0 = 8'h00; tb_en0 = 1'b0;
        t2 = 1'b1; i2 = 8'h00; tb_b2 = 8'h00; tb_en2 = 1'b0;
        t3 = 1'b1; i3 = 8'h00; tb_b3 = 8'h00; tb_en3 = 1'b0;
        tb_b4 = 8'h77; tb_en4 = 1'b1;

        // Reset state
        tick();
        tick();
        check("rst_cnt0", 32'(cnt0), 32'h0);
        check("rst_o4", 32'(o4), 32'h0);
        check("rst_drv2", 32'(drv2), 32'h0);
        check("rst_cnt1", 32'(cnt1), 32'h0);
        ft2232_reset_n_i = 1'b1;

        // T=1: pad released, reads bench value
        tb_b0 = 8'hC1; tb_en0 = 1'b1;
        #1;
        check("rx_o0", 32'(o0), 32'hC1);
        check("rx_b0", 32'(b0), 32'hC1);
        check("rx_drv0", 32'(drv0), 32'h0);

        tick();                                   // edge 1: T=1, no turn
        t0 = 1'b0; i0 = 8'h3F; tb_en0 = 1'b0;
        #1;
        check("tx_b0", 32'(b0), 32'h3F);
        check("tx_o0", 32'(o0), 32'h3F);
        check("tx_drv0", 32'(drv0), 32'h1);
        check("tx_b1", 32'(b1), 32'h3F);

        tick();                                   // edge 2: 1->0
        t0 = 1'b1;
        tick();                                   // edge 3: 0->1
        t0 = 1'b0;
        tick();                                   // edge 4: 1->0
        check("turn_cnt0_3", 32'(cnt0), 32'd3);
        check("turn_cnt1_3", 32'(cnt1), 32'd3);
        t0 = 1'b1;
        tick();                                   // 4th toggle
        t0 = 1'b0;
        tick();                                   // 5th toggle
        check("turn_cnt0_5", 32'(cnt0), 32'd5);
        check("turn_cnt1_sat", 32'(cnt1), 32'd3);
        t0 = 1'b1;
        #1;
        check("rel_drv0", 32'(drv0), 32'h0);

        // INPUT bank ignores T and I
        t3 = 1'b0; i3 = 8'hAA; tb_b3 = 8'h12; tb_en3 = 1'b1;
        #1;
        check("in_b3", 32'(b3), 32'h12);
        check("in_o3", 32'(o3), 32'h12);
        check("in_drv3", 32'(drv3), 32'h0);
        tick();
        t3 = 1'b1;
        tick();
        check("in_cnt3", 32'(cnt3), 32'h0);

        // Registered read path
        tb_b4 = 8'h01;
        tick();
        check("regin_o4_01", 32'(o4), 32'h01);
        tb_b4 = 8'h02;
        #1;
        check("regin_o4_hold", 32'(o4), 32'h01);
        tick();
        check("regin_o4_02", 32'(o4), 32'h02);

        // Registered drive path: one cycle latency
        t2 = 1'b0; i2 = 8'h55;
        #1;
        check("regout_drv2_pre", 32'(drv2), 32'h0);
        tick();
        check("regout_b2", 32'(b2), 32'h55);
        check("regout_drv2", 32'(drv2), 32'h1);
        check("regout_cnt2_0", 32'(cnt2), 32'h0);
        tick();
        check("regout_cnt2_1", 32'(cnt2), 32'h1);

        // Async reset mid-drive releases the pad at once
        #2;
        ft2232_reset_n_i = 1'b0;
        tb_b2 = 8'hA0; tb_en2 = 1'b1;
        #1;
        check("rst_mid_b2", 32'(b2), 32'hA0);
        check("rst_mid_drv2", 32'(drv2), 32'h0);
        check("rst_mid_cnt2", 32'(cnt2), 32'h0);
        check("rst_mid_o4", 32'(o4), 32'h0);
        check("rst_mid_cnt0", 32'(cnt0), 32'h0);

        // Unregistered bank is not gated by reset
        tb_en0 = 1'b0; t0 = 1'b0; i0 = 8'h9C;
        #1;
        check("rst_nogate_b0", 32'(b0), 32'h9C);
        check("rst_nogate_drv0", 32'(drv0), 32'h1);

        ft2232_reset_n_i = 1'b1;
        tick();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
